control_unit: RTL and testbench

Moore-style sequencer that generates every datapath control strobe for the Mini SRC processor, one instruction at a time. It sits directly upstream of `new_datapath`: its inputs are the datapath's `IR` and `CONout`, and its outputs drive that datapath's control ports. It replaces hand-sequenced testbench stimulus. It runs a fixed fetch (T0–T2), then an opcode-specific execute sequence (T3–T7), then either loops back to T0 or halts.

---
 rtl/control_unit.sv | 233 +++++++++++++++++++++++
 tb/tb_control_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// control_unit: Moore sequencer producing every datapath control strobe for the
// Mini SRC processor. Runs a fixed fetch (T0-T2), then an opcode-specific execute
// sequence (T3-T7), then returns to T0 or halts.
// Ports:
//   Clock, GlobalReset (async, active-low)
//   IR[31:0]   instruction register (opcode in [31:27])
//   CONout     branch condition from the datapath
//   Stop       halt request, honoured only in an instruction's final state
//   Run        high while executing (T0-T7)
//   strobes    datapath / memory / register-file control strobes
//   ALUControl ALU operation select
// Strobes are decoded combinationally from the registered state plus IR/CONout,
// so they are valid for the whole state cycle.
module control_unit #(
    parameter int unsigned RESET_STATE_CYCLES = 1,
    parameter logic [4:0]  ALU_ADD            = 5'b00011
) (
    input  logic        Clock,
    input  logic        GlobalReset,
    input  logic [31:0] IR,
    input  logic        CONout,
    input  logic        Stop,
    output logic        Run,
    output logic        PCout,
    output logic        PCin,
    output logic        PCinc,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        Zhiout,
    output logic        Zloout,
    output logic        HIin,
    output logic        HIout,
    output logic        LOin,
    output logic        LOout,
    output logic        Read,
    output logic        write,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        Cout,
    output logic        CONin,
    output logic        IN_portout,
    output logic        OUT_portin,
    output logic [4:0]  ALUControl
);

    localparam int unsigned CNT_W = 16;

    localparam logic [4:0] OP_LD   = 5'd0;
    localparam logic [4:0] OP_LDI  = 5'd1;
    localparam logic [4:0] OP_ST   = 5'd2;
    localparam logic [4:0] OP_DIV  = 5'd15;
    localparam logic [4:0] OP_MUL  = 5'd16;
    localparam logic [4:0] OP_NEG  = 5'd17;
    localparam logic [4:0] OP_NOT  = 5'd18;
    localparam logic [4:0] OP_BRX  = 5'd19;
    localparam logic [4:0] OP_JR   = 5'd20;
    localparam logic [4:0] OP_JAL  = 5'd21;
    localparam logic [4:0] OP_IN   = 5'd22;
    localparam logic [4:0] OP_OUT  = 5'd23;
    localparam logic [4:0] OP_MFHI = 5'd24;
    localparam logic [4:0] OP_MFLO = 5'd25;
    localparam logic [4:0] OP_HALT = 5'd27;

    // T0-T7 share their step index with the low three bits
    typedef enum logic [3:0] {
        S_T0     = 4'd0,
        S_T1     = 4'd1,
        S_T2     = 4'd2,
        S_T3     = 4'd3,
        S_T4     = 4'd4,
        S_T5     = 4'd5,
        S_T6     = 4'd6,
        S_T7     = 4'd7,
        S_RESET  = 4'd8,
        S_HALTED = 4'd9
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] reset_cnt;
    logic             reset_done;
    logic [4:0]       opcode;
    logic             is_alu;
    logic             is_imm;
    logic             is_mem;
    logic             is_muldiv;
    logic             is_negnot;
    logic             unused_ir;

    assign opcode    = IR[31:27];
    assign unused_ir = ^IR[26:0];
    assign is_alu    = (opcode >= 5'd3) && (opcode <= 5'd11);
    assign is_imm    = (opcode >= 5'd12) && (opcode <= 5'd14);
    assign is_mem    = (opcode == OP_LD) || (opcode == OP_LDI) || (opcode == OP_ST);
    assign is_muldiv = (opcode == OP_MUL) || (opcode == OP_DIV);
    assign is_negnot = (opcode == OP_NEG) || (opcode == OP_NOT);

    assign reset_done = (32'(reset_cnt) + 32'd1) >= RESET_STATE_CYCLES;

    // Index of the final execute step for an opcode (undefined opcodes act as nop)
    function automatic logic [2:0] last_step(input logic [4:0] op);
        logic [2:0] step;
        step = 3'd3;
        if ((op >= 5'd3 && op <= 5'd14) || op == OP_LDI)  step = 3'd5;
        else if (op == OP_LD || op == OP_ST)               step = 3'd7;
        else if (op == OP_MUL || op == OP_DIV || op == OP_BRX) step = 3'd6;
        else if (op == OP_NEG || op == OP_NOT || op == OP_JAL) step = 3'd4;
        return step;
    endfunction

    // State register and post-reset dwell counter
    always_ff @(posedge Clock or negedge GlobalReset) begin
        if (!GlobalReset) begin
            state     <= S_RESET;
            reset_cnt <= '0;
        end else begin
            state     <= next_state;
            reset_cnt <= (state == S_RESET) ? reset_cnt + CNT_W'(1) : '0;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_RESET:  if (reset_done) next_state = S_T0;
            S_T0:     next_state = S_T1;
            S_T1:     next_state = S_T2;
            S_T2:     next_state = S_T3;
            S_T3, S_T4, S_T5, S_T6, S_T7: begin
                if (state[2:0] == last_step(opcode)) begin
                    next_state = (opcode == OP_HALT || Stop) ? S_HALTED : S_T0;
                end else begin
                    next_state = state_t'(state + 4'd1);
                end
            end
            S_HALTED: next_state = S_HALTED;
            default:  next_state = S_RESET;
        endcase
    end

    // Output decode from {state, opcode, CONout}
    always_comb begin
        {PCout, PCin, PCinc, MARin, MDRin, MDRout, IRin, Yin, Zin, Zhiout, Zloout,
         HIin, HIout, LOin, LOout, Read, write, Gra, Grb, Grc, Rin, Rout, BAout,
         Cout, CONin, IN_portout, OUT_portin} = '0;
        ALUControl = '0;
        Run        = (state != S_RESET) && (state != S_HALTED);
        case (state)
            S_T0: begin PCout = 1'b1; MARin = 1'b1; PCinc = 1'b1; end
            S_T1: begin Read = 1'b1; MDRin = 1'b1; end
            S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
            S_T3: begin
                if (is_alu || is_imm) begin
                    Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                end else if (is_mem) begin
                    Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
                end else if (is_muldiv) begin
                    Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
                end else if (is_negnot) begin
                    Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; ALUControl = opcode;
                end else begin
                    case (opcode)
                        OP_BRX:  begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
                        OP_JR:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                        OP_JAL:  begin PCout = 1'b1; Grb = 1'b1; Rin = 1'b1; end
                        OP_IN:   begin IN_portout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                        OP_OUT:  begin Gra = 1'b1; Rout = 1'b1; OUT_portin = 1'b1; end
                        OP_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                        OP_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                        default: ;
                    endcase
                end
            end
            S_T4: begin
                if (is_alu) begin
                    Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; ALUControl = opcode;
                end else if (is_imm) begin
                    Cout = 1'b1; Zin = 1'b1; ALUControl = opcode;
                end else if (is_mem) begin
                    Cout = 1'b1; Zin = 1'b1; ALUControl = ALU_ADD;
                end else if (is_muldiv) begin
                    Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; ALUControl = opcode;
                end else if (is_negnot) begin
                    Zloout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (opcode == OP_BRX) begin
                    PCout = 1'b1; Yin = 1'b1;
                end else if (opcode == OP_JAL) begin
                    Gra = 1'b1; Rout = 1'b1; PCin = 1'b1;
                end
            end
            S_T5: begin
                if (is_alu || is_imm || opcode == OP_LDI) begin
                    Zloout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (opcode == OP_LD || opcode == OP_ST) begin
                    Zloout = 1'b1; MARin = 1'b1;
                end else if (is_muldiv) begin
                    Zloout = 1'b1; LOin = 1'b1;
                end else if (opcode == OP_BRX) begin
                    Cout = 1'b1; Zin = 1'b1; ALUControl = ALU_ADD;
                end
            end
            S_T6: begin
                if (opcode == OP_LD) begin
                    Read = 1'b1; MDRin = 1'b1;
                end else if (opcode == OP_ST) begin
                    Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
                end else if (is_muldiv) begin
                    Zhiout = 1'b1; HIin = 1'b1;
                end else if (opcode == OP_BRX && CONout) begin
                    Zloout = 1'b1; PCin = 1'b1;
                end
            end
            S_T7: begin
                if (opcode == OP_LD) begin
                    MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (opcode == OP_ST) begin
                    write = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Testbench for control_unit: per-cycle strobe checks against a micro-step table
// model derived from the instruction set, plus reset, halt and Stop sequences.
module tb_control_unit;

    logic        Clock = 1'b0;
    logic        GlobalReset = 1'b1;
    logic [31:0] IR = '0;
    logic        CONout = 1'b0;
    logic        Stop = 1'b0;
    logic        Run;
    logic PCout, PCin, PCinc, MARin, MDRin, MDRout, IRin, Yin, Zin, Zhiout, Zloout;
    logic HIin, HIout, LOin, LOout, Read, write, Gra, Grb, Grc, Rin, Rout, BAout;
    logic Cout, CONin, IN_portout, OUT_portin;
    logic [4:0] ALUControl;

    control_unit dut (
        .Clock(Clock), .GlobalReset(GlobalReset), .IR(IR), .CONout(CONout), .Stop(Stop),
        .Run(Run), .PCout(PCout), .PCin(PCin), .PCinc(PCinc), .MARin(MARin),
        .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin),
        .Zhiout(Zhiout), .Zloout(Zloout), .HIin(HIin), .HIout(HIout), .LOin(LOin),
        .LOout(LOout), .Read(Read), .write(write), .Gra(Gra), .Grb(Grb), .Grc(Grc),
        .Rin(Rin), .Rout(Rout), .BAout(BAout), .Cout(Cout), .CONin(CONin),
        .IN_portout(IN_portout), .OUT_portin(OUT_portin), .ALUControl(ALUControl)
    );

    always #5 Clock = ~Clock;

    logic [26:0] strobes;
    assign strobes = {PCout, PCin, PCinc, MARin, MDRin, MDRout, IRin, Yin, Zin, Zhiout,
                      Zloout, HIin, HIout, LOin, LOout, Read, write, Gra, Grb, Grc, Rin,
                      Rout, BAout, Cout, CONin, IN_portout, OUT_portin};

    localparam logic [26:0] PCOUT = 27'd1 << 26, PCIN   = 27'd1 << 25, PCINC  = 27'd1 << 24;
    localparam logic [26:0] MARIN = 27'd1 << 23, MDRIN  = 27'd1 << 22, MDROUT = 27'd1 << 21;
    localparam logic [26:0] IRIN  = 27'd1 << 20, YIN    = 27'd1 << 19, ZIN    = 27'd1 << 18;
    localparam logic [26:0] ZHI   = 27'd1 << 17, ZLO    = 27'd1 << 16, HIIN   = 27'd1 << 15;
    localparam logic [26:0] HIOUT = 27'd1 << 14, LOIN   = 27'd1 << 13, LOOUT  = 27'd1 << 12;
    localparam logic [26:0] READ  = 27'd1 << 11, WRITE  = 27'd1 << 10, GRA    = 27'd1 << 9;
    localparam logic [26:0] GRB   = 27'd1 << 8,  GRC    = 27'd1 << 7,  RIN    = 27'd1 << 6;
    localparam logic [26:0] ROUT  = 27'd1 << 5,  BAOUT  = 27'd1 << 4,  COUT   = 27'd1 << 3;
    localparam logic [26:0] CONIN = 27'd1 << 2,  INPORT = 27'd1 << 1,  OUTPORT = 27'd1;
    localparam logic [26:0] T0V   = PCOUT | MARIN | PCINC;
    localparam logic [4:0]  ADD_CODE = 5'b00011;

    typedef struct packed {
        logic [26:0] s;
        logic [4:0]  alu;
    } step_t;

    typedef struct {
        logic [31:0] ir;
        logic        con;
        int          lat;
    } vec_t;

    step_t exp_q[$];
    int    n_cmp = 0;
    int    n_err = 0;

    function automatic void push(input logic [26:0] s, input logic [4:0] a);
        exp_q.push_back({s, a});
    endfunction

    // Micro-step list of one instruction, written straight from the instruction table
    function automatic void build(input logic [4:0] op, input logic con);
        int o;
        o = int'(op);
        exp_q.delete();
        push(T0V, 5'd0); push(READ | MDRIN, 5'd0); push(MDROUT | IRIN, 5'd0);
        if (o >= 3 && o <= 11) begin
            push(GRB | ROUT | YIN, 5'd0); push(GRC | ROUT | ZIN, op); push(ZLO | GRA | RIN, 5'd0);
        end else if (o >= 12 && o <= 14) begin
            push(GRB | ROUT | YIN, 5'd0); push(COUT | ZIN, op); push(ZLO | GRA | RIN, 5'd0);
        end else if (o <= 2) begin
            push(GRB | BAOUT | YIN, 5'd0); push(COUT | ZIN, ADD_CODE);
            if (o == 1) push(ZLO | GRA | RIN, 5'd0);
            else if (o == 0) begin
                push(ZLO | MARIN, 5'd0); push(READ | MDRIN, 5'd0); push(MDROUT | GRA | RIN, 5'd0);
            end else begin
                push(ZLO | MARIN, 5'd0); push(GRA | ROUT | MDRIN, 5'd0); push(WRITE, 5'd0);
            end
        end else begin
            case (o)
                15, 16: begin
                    push(GRA | ROUT | YIN, 5'd0); push(GRB | ROUT | ZIN, op);
                    push(ZLO | LOIN, 5'd0); push(ZHI | HIIN, 5'd0);
                end
                17, 18: begin push(GRB | ROUT | ZIN, op); push(ZLO | GRA | RIN, 5'd0); end
                19: begin
                    push(GRA | ROUT | CONIN, 5'd0); push(PCOUT | YIN, 5'd0);
                    push(COUT | ZIN, ADD_CODE); push(con ? (ZLO | PCIN) : 27'd0, 5'd0);
                end
                20: push(GRA | ROUT | PCIN, 5'd0);
                21: begin push(PCOUT | GRB | RIN, 5'd0); push(GRA | ROUT | PCIN, 5'd0); end
                22: push(INPORT | GRA | RIN, 5'd0);
                23: push(GRA | ROUT | OUTPORT, 5'd0);
                24: push(HIOUT | GRA | RIN, 5'd0);
                25: push(LOOUT | GRA | RIN, 5'd0);
                default: push(27'd0, 5'd0);
            endcase
        end
    endfunction

    task automatic check(input string name, input logic [26:0] es, input logic [4:0] ea,
                         input logic er);
        n_cmp++;
        if (strobes !== es || ALUControl !== ea || Run !== er) begin
            n_err++;
            $display("FAIL %s: got strobes=%h alu=%b run=%b, want strobes=%h alu=%b run=%b",
                     name, strobes, ALUControl, Run, es, ea, er);
        end
    endtask

    // Asserts reset asynchronously, releases it and leaves the bench 1ns into T0
    task automatic do_reset();
        GlobalReset = 1'b0;
        Stop = 1'b0;
        #1;
        check("reset_async", 27'd0, 5'd0, 1'b0);
        @(posedge Clock); @(posedge Clock); #1;
        GlobalReset = 1'b1;
        @(negedge Clock);
        check("reset_hold", 27'd0, 5'd0, 1'b0);
        @(posedge Clock); #1;
        check("reset_exit_t0", T0V, 5'd0, 1'b1);
    endtask

    // Runs one instruction starting 1ns into its T0; lat=0 takes the model's length
    task automatic run_instr(input logic [31:0] ir, input logic con, input logic stop_last,
                             input logic noise, input int lat, output logic halted);
        int n;
        IR = ir;
        CONout = con;
        build(ir[31:27], con);
        n = (lat > 0) ? lat : exp_q.size();
        for (int k = 0; k < n; k++) begin
            if (k > 0) begin @(posedge Clock); #1; end
            Stop = (k == n - 1) ? stop_last : (noise ? 1'($urandom_range(0, 1)) : 1'b0);
            @(negedge Clock);
            if (k < exp_q.size())
                check($sformatf("op%0d_step%0d", ir[31:27], k), exp_q[k].s, exp_q[k].alu, 1'b1);
            else
                check($sformatf("op%0d_step%0d", ir[31:27], k), 27'd0, 5'd0, 1'b1);
        end
        halted = (ir[31:27] == 5'd27) || stop_last;
        @(posedge Clock); #1;
        Stop = 1'b0;
        if (halted) check($sformatf("op%0d_halted", ir[31:27]), 27'd0, 5'd0, 1'b0);
        else        check($sformatf("op%0d_next_t0", ir[31:27]), T0V, 5'd0, 1'b1);
    endtask

    vec_t tbl[21];
    logic h;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, want finished");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{32'h18918000, 1'b0, 6};  // add
        tbl[1]  = '{32'h20918000, 1'b0, 6};  // sub
        tbl[2]  = '{32'h60900000, 1'b0, 6};  // addi
        tbl[3]  = '{32'h08900000, 1'b0, 6};  // ldi
        tbl[4]  = '{32'h00900000, 1'b0, 8};  // ld
        tbl[5]  = '{32'h10900000, 1'b0, 8};  // st
        tbl[6]  = '{32'h80900000, 1'b0, 7};  // mul
        tbl[7]  = '{32'h78900000, 1'b0, 7};  // div
        tbl[8]  = '{32'h88900000, 1'b0, 5};  // neg
        tbl[9]  = '{32'h90900000, 1'b0, 5};  // not
        tbl[10] = '{32'h98800000, 1'b0, 7};  // brx, not taken
        tbl[11] = '{32'h98800000, 1'b1, 7};  // brx, taken
        tbl[12] = '{32'hA0800000, 1'b0, 4};  // jr
        tbl[13] = '{32'hAAF80000, 1'b0, 5};  // jal R5, link R15
        tbl[14] = '{32'hB0800000, 1'b0, 4};  // in
        tbl[15] = '{32'hB8800000, 1'b0, 4};  // out
        tbl[16] = '{32'hC0800000, 1'b0, 4};  // mfhi
        tbl[17] = '{32'hC8800000, 1'b0, 4};  // mflo
        tbl[18] = '{32'hD0000000, 1'b0, 4};  // nop
        tbl[19] = '{32'hE0000000, 1'b0, 4};  // undefined
        tbl[20] = '{32'hF8000000, 1'b0, 4};  // undefined

        #2;
        do_reset();

        foreach (tbl[i]) run_instr(tbl[i].ir, tbl[i].con, 1'b0, 1'b0, tbl[i].lat, h);

        // reset in the middle of an add's T4
        IR = 32'h18918000;
        repeat (4) @(posedge Clock);
        #3;
        check("add_t4_before_reset", GRC | ROUT | ZIN, 5'b00011, 1'b1);
        do_reset();

        // halt instruction holds Halted
        run_instr(32'hD8000000, 1'b0, 1'b0, 1'b0, 4, h);
        repeat (20) begin @(negedge Clock); check("halt_hold", 27'd0, 5'd0, 1'b0); end
        do_reset();

        // Stop in ld's final state
        run_instr(32'h00900000, 1'b0, 1'b1, 1'b0, 8, h);
        repeat (20) begin @(negedge Clock); check("stop_hold", 27'd0, 5'd0, 1'b0); end
        do_reset();

        // Stop toggling outside the final state must be ignored
        run_instr(32'h10900000, 1'b0, 1'b0, 1'b1, 8, h);

        // random instructions, random CONout, random Stop
        for (int r = 0; r < 120; r++) begin
            run_instr($urandom, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                      1'b1, 0, h);
            if (h) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
